// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   start      request, sampled only while idle
//   dividend   numerator (DIVIDEND_W), captured on accepted start
//   divisor    denominator (DIVISOR_W), captured on accepted start
//   busy       high while the divide loop runs
//   done       one-cycle pulse, results valid
//   quotient   registered quotient, held until next completion
//   remainder  registered remainder, held until next completion
//   div_zero   registered, high if the last operation had divisor == 0
//
// Optional build macro: DIV_ROUND_EN (round quotient half up, saturating).
module seq_divider #(
  parameter int DIVIDEND_W = 9,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ZERO   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // dvd_q holds the dividend at the start and shifts left each step; the
  // freshly decided quotient bit enters at the LSB, so after DIVIDEND_W
  // steps the register holds the full quotient.
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W-1:0]  part_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DIVISOR_W:0]    shifted;
  logic                  ge;
  logic [DIVISOR_W-1:0]  diff;
  logic [DIVISOR_W-1:0]  new_rem;
  logic [DIVIDEND_W-1:0] q_next;
  logic [DIVIDEND_W-1:0] q_final;

  // Partial remainder is always < divisor, so it fits DIVISOR_W bits at rest;
  // only the shifted value needs the extra bit.
  assign shifted = {part_q, dvd_q[DIVIDEND_W-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  // The true difference is < divisor, so modulo-2^DIVISOR_W subtraction is exact.
  assign diff    = shifted[DIVISOR_W-1:0] - dvs_q;
  assign new_rem = ge ? diff : shifted[DIVISOR_W-1:0];
  assign q_next  = {dvd_q[DIVIDEND_W-2:0], ge};

`ifdef DIV_ROUND_EN
  logic round_up;
  assign round_up = ({new_rem, 1'b0} >= {1'b0, dvs_q});
  assign q_final  = (round_up && !(&q_next)) ? q_next + 1'b1 : q_next;
`else
  assign q_final = q_next;
`endif

  assign busy = (state == DIVIDE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? ZERO : DIVIDE;
        end
      end
      DIVIDE: begin
        if (cnt_q == '0) begin
          state_nxt = DONE;
        end
      end
      ZERO:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      part_q    <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            part_q <= '0;
            cnt_q  <= CNT_INIT;
          end
        end
        DIVIDE: begin
          dvd_q  <= q_next;
          part_q <= new_rem;
          if (cnt_q == '0) begin
            quotient  <= q_final;
            remainder <= new_rem;
            div_zero  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ZERO: begin
          quotient  <= '1;
          remainder <= dvd_q[DIVISOR_W-1:0];
          div_zero  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

  localparam int DW = 9;
  localparam int VW = 4;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
  } exp_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q_trunc;
    logic [DW-1:0] q_round;
    logic [VW-1:0] r;
    logic          dz;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t pick(input vec_t v);
    exp_t e;
`ifdef DIV_ROUND_EN
    e.q = v.q_round;
`else
    e.q = v.q_trunc;
`endif
    e.r  = v.r;
    e.dz = v.dz;
    return e;
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (n_rst) begin
      check("busy_done_excl", int'(busy && done), 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", int'(quotient), int'(e.q));
          check("remainder", int'(remainder), int'(e.r));
          check("div_zero", int'(div_zero), int'(e.dz));
        end
      end
    end
  end

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input exp_t e);
    int cyc;
    int bcyc;
    bit seen;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    cyc  = 0;
    bcyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
      if (done) seen = 1'b1;
    end
    check("done_timeout", int'(seen), 1);
    if (seen) begin
      check("latency", cyc, (b == 0) ? 2 : DW + 1);
      check("busy_cycles", bcyc, (b == 0) ? 0 : DW);
    end
  endtask

  localparam int NV = 13;
  vec_t vecs[NV];
  exp_t e;
  vec_t v;

  initial begin
    vecs[0]  = '{9'd117, 4'd9,  9'd13,  9'd13,  4'd0, 1'b0};
    vecs[1]  = '{9'd225, 4'd15, 9'd15,  9'd15,  4'd0, 1'b0};
    vecs[2]  = '{9'd511, 4'd1,  9'd511, 9'd511, 4'd0, 1'b0};
    vecs[3]  = '{9'd5,   4'd15, 9'd0,   9'd0,   4'd5, 1'b0};
    vecs[4]  = '{9'd50,  4'd0,  9'd511, 9'd511, 4'd2, 1'b1};
    vecs[5]  = '{9'd100, 4'd7,  9'd14,  9'd14,  4'd2, 1'b0};
    vecs[6]  = '{9'd102, 4'd7,  9'd14,  9'd15,  4'd4, 1'b0};
    vecs[7]  = '{9'd101, 4'd7,  9'd14,  9'd14,  4'd3, 1'b0};
    vecs[8]  = '{9'd200, 4'd3,  9'd66,  9'd67,  4'd2, 1'b0};
    vecs[9]  = '{9'd0,   4'd5,  9'd0,   9'd0,   4'd0, 1'b0};
    vecs[10] = '{9'd511, 4'd15, 9'd34,  9'd34,  4'd1, 1'b0};
    vecs[11] = '{9'd255, 4'd2,  9'd127, 9'd128, 4'd1, 1'b0};
    vecs[12] = '{9'd511, 4'd2,  9'd255, 9'd256, 4'd1, 1'b0};

    n_rst    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_div_zero", int'(div_zero), 0);
    n_rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      run_op(v.a, v.b, pick(v));
    end

    // Start requests during DIVIDE and DONE must be ignored.
    begin
      int  extra;
      int  bseen;
      bit  seen;
      @(negedge clk);
      dividend = 9'd100;
      divisor  = 4'd7;
      start    = 1'b1;
      e.q = 9'd14; e.r = 4'd2; e.dz = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      dividend = 9'd30;
      divisor  = 4'd5;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("prot_done_timeout", int'(seen), 1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      extra = 0;
      bseen = 0;
      repeat (15) begin
        @(negedge clk);
        if (done) extra++;
        if (busy) bseen++;
      end
      check("prot_extra_done", extra, 0);
      check("prot_busy_after", bseen, 0);
      check("prot_q_held", int'(quotient), 14);
      check("prot_r_held", int'(remainder), 2);
    end

    // Reset in the middle of a divide aborts it at once.
    @(negedge clk);
    dividend = 9'd200;
    divisor  = 4'd3;
    start    = 1'b1;
    e.q = 9'd0; e.r = 4'd0; e.dz = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_quotient", int'(quotient), 0);
    check("mid_rst_remainder", int'(remainder), 0);
    check("mid_rst_div_zero", int'(div_zero), 0);
    sb.delete();
    @(negedge clk);
    n_rst = 1'b1;
`ifdef DIV_ROUND_EN
    e.q = 9'd67;
`else
    e.q = 9'd66;
`endif
    e.r  = 4'd2;
    e.dz = 1'b0;
    run_op(9'd200, 4'd3, e);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
